// File: rtl/stopwatch_display.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | stopwatch_display: MM.SS on a 4-digit multiplexed 7-segment display,     |
// | one tear-free snapshot per frame. Option macro: STOPWATCH_BLINK_EN.      |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module stopwatch_display #(
  parameter int CLK_HZ     = 100_000_000,
  parameter int REFRESH_HZ = 1000,
  parameter int BLINK_HZ   = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] minutes,
  input  logic [5:0] seconds,
  input  logic       blank,
`ifdef STOPWATCH_BLINK_EN
  input  logic       blink,
`endif
  output logic [6:0] seg,
  output logic [3:0] an,
  output logic       dp
);

  localparam int               c_div      = CLK_HZ / REFRESH_HZ;
  localparam int               c_cw       = (c_div > 1) ? $clog2(c_div) : 1;
  localparam logic [c_cw-1:0]  c_last     = c_cw'(c_div - 1);
  localparam logic [6:0]       c_seg_off  = 7'h7F;
  localparam logic [6:0]       c_seg_dash = 7'h3F;

  logic [c_cw-1:0] r_cnt;
  logic [1:0]      r_idx;
  logic            r_live;
  logic [5:0]      r_min;
  logic [5:0]      r_sec;

  logic            w_tick;
  logic            w_live_nxt;
  logic [1:0]      w_idx_nxt;
  logic [5:0]      w_min_nxt;
  logic [5:0]      w_sec_nxt;
  logic [7:0]      w_min_bcd;
  logic [7:0]      w_sec_bcd;
  logic [3:0]      w_nib;
  logic            w_dash;
  logic            w_blank_eff;

  function automatic logic [7:0] to_bcd(input logic [5:0] v);
    logic [3:0] t;
    logic [3:0] o;
    if (v >= 6'd50) begin
      t = 4'd5; o = 4'(v - 6'd50);
    end else if (v >= 6'd40) begin
      t = 4'd4; o = 4'(v - 6'd40);
    end else if (v >= 6'd30) begin
      t = 4'd3; o = 4'(v - 6'd30);
    end else if (v >= 6'd20) begin
      t = 4'd2; o = 4'(v - 6'd20);
    end else if (v >= 6'd10) begin
      t = 4'd1; o = 4'(v - 6'd10);
    end else begin
      t = 4'd0; o = v[3:0];
    end
    return {t, o};
  endfunction

  function automatic logic [6:0] seg_code(input logic [3:0] d);
    case (d)
      4'd0:    return 7'h40;
      4'd1:    return 7'h79;
      4'd2:    return 7'h24;
      4'd3:    return 7'h30;
      4'd4:    return 7'h19;
      4'd5:    return 7'h12;
      4'd6:    return 7'h02;
      4'd7:    return 7'h78;
      4'd8:    return 7'h00;
      4'd9:    return 7'h10;
      default: return c_seg_dash;
    endcase
  endfunction

  assign w_tick = (r_cnt == c_last);

  // The first tick after reset only lights digit 0; later ticks advance the
  // scan, and the 3->0 wrap loads the snapshot for the new frame.
  always_comb begin
    w_live_nxt = r_live | w_tick;
    w_idx_nxt  = r_idx;
    w_min_nxt  = r_min;
    w_sec_nxt  = r_sec;
    if (w_tick && r_live) begin
      w_idx_nxt = r_idx + 2'd1;
      if (r_idx == 2'd3) begin
        w_min_nxt = minutes;
        w_sec_nxt = seconds;
      end
    end
  end

  assign w_min_bcd = to_bcd(w_min_nxt);
  assign w_sec_bcd = to_bcd(w_sec_nxt);

  always_comb begin
    w_nib  = 4'd0;
    w_dash = 1'b0;
    case (w_idx_nxt)
      2'd0: begin w_nib = w_sec_bcd[3:0]; w_dash = (w_sec_nxt > 6'd59); end
      2'd1: begin w_nib = w_sec_bcd[7:4]; w_dash = (w_sec_nxt > 6'd59); end
      2'd2: begin w_nib = w_min_bcd[3:0]; w_dash = (w_min_nxt > 6'd59); end
      default: begin w_nib = w_min_bcd[7:4]; w_dash = (w_min_nxt > 6'd59); end
    endcase
  end

`ifdef STOPWATCH_BLINK_EN
  localparam int              c_half = CLK_HZ / (2 * BLINK_HZ);
  localparam int              c_hw   = (c_half > 1) ? $clog2(c_half) : 1;
  localparam logic [c_hw-1:0] c_hlast = c_hw'(c_half - 1);

  logic [c_hw-1:0] r_bcnt;
  logic            r_phase;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_bcnt  <= '0;
      r_phase <= 1'b0;
    end else if (r_bcnt == c_hlast) begin
      r_bcnt  <= '0;
      r_phase <= ~r_phase;
    end else begin
      r_bcnt  <= r_bcnt + c_hw'(1);
    end
  end

  assign w_blank_eff = blank | (blink & r_phase);
`else
  // A nonpositive blink rate is a misconfiguration; keep the display dark.
  localparam logic c_blink_ok = (BLINK_HZ > 0);
  assign w_blank_eff = blank | ~c_blink_ok;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt  <= '0;
      r_idx  <= 2'd0;
      r_live <= 1'b0;
      r_min  <= 6'd0;
      r_sec  <= 6'd0;
    end else begin
      r_cnt  <= w_tick ? '0 : r_cnt + c_cw'(1);
      r_idx  <= w_idx_nxt;
      r_live <= w_live_nxt;
      r_min  <= w_min_nxt;
      r_sec  <= w_sec_nxt;
    end
  end

  // Outputs are decoded from next state so they move on the same edge as idx.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      seg <= c_seg_off;
      an  <= 4'hF;
      dp  <= 1'b1;
    end else if (!w_live_nxt || w_blank_eff) begin
      seg <= c_seg_off;
      an  <= 4'hF;
      dp  <= 1'b1;
    end else begin
      seg <= w_dash ? c_seg_dash : seg_code(w_nib);
      an  <= ~(4'b0001 << w_idx_nxt);
      dp  <= ~(w_idx_nxt == 2'd2);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_stopwatch_display.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_stopwatch_display: directed bench for stopwatch_display (DIV=4).      |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_stopwatch_display;

  logic       clk;
  logic       reset;
  logic [5:0] minutes;
  logic [5:0] seconds;
  logic       blank;
  logic [6:0] seg;
  logic [3:0] an;
  logic       dp;
`ifdef STOPWATCH_BLINK_EN
  logic       blink;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  stopwatch_display #(
    .CLK_HZ    (1000),
    .REFRESH_HZ(250),
    .BLINK_HZ  (50)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .minutes(minutes),
    .seconds(seconds),
    .blank  (blank),
`ifdef STOPWATCH_BLINK_EN
    .blink  (blink),
`endif
    .seg    (seg),
    .an     (an),
    .dp     (dp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_disp(input string tag, input logic [3:0] e_an,
                            input logic [6:0] e_seg, input logic e_dp);
    check_val({tag, ".an"},  32'(an),  32'(e_an));
    check_val({tag, ".seg"}, 32'(seg), 32'(e_seg));
    check_val({tag, ".dp"},  32'(dp),  32'(e_dp));
  endtask

  task automatic waitclk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    reset   = 1'b1;
    minutes = 6'd12;
    seconds = 6'd34;
    blank   = 1'b0;
`ifdef STOPWATCH_BLINK_EN
    blink   = 1'b0;
`endif
    waitclk(3);
    check_disp("reset", 4'hF, 7'h7F, 1'b1);
    reset = 1'b0;

    // First frame shows the reset snapshot 00.00
    waitclk(3); check_disp("pre_tick", 4'hF, 7'h7F, 1'b1);
    waitclk(1); check_disp("f0_d0", 4'hE, 7'h40, 1'b1);
    waitclk(4); check_disp("f0_d1", 4'hD, 7'h40, 1'b1);
    waitclk(4); check_disp("f0_d2", 4'hB, 7'h40, 1'b0);
    waitclk(4); check_disp("f0_d3", 4'h7, 7'h40, 1'b1);

    // 12:34 frame, seconds change mid-frame
    waitclk(4); check_disp("f1_d0", 4'hE, 7'h19, 1'b1);
    waitclk(3); check_disp("f1_d0_hold", 4'hE, 7'h19, 1'b1);
    waitclk(1); check_disp("f1_d1", 4'hD, 7'h30, 1'b1);
    seconds = 6'd35;
    waitclk(4); check_disp("f1_d2", 4'hB, 7'h24, 1'b0);
    waitclk(4); check_disp("f1_d3", 4'h7, 7'h79, 1'b1);
    waitclk(4); check_disp("f2_d0", 4'hE, 7'h12, 1'b1);

    // Asynchronous reset mid-scan
    waitclk(1);
    #2 reset = 1'b1;
    #1 check_disp("async_rst", 4'hF, 7'h7F, 1'b1);
    @(posedge clk); #1;
    reset   = 1'b0;
    minutes = 6'd59;
    seconds = 6'd60;
    waitclk(3); check_disp("rst_pre_tick", 4'hF, 7'h7F, 1'b1);
    waitclk(1); check_disp("rst_d0", 4'hE, 7'h40, 1'b1);
    waitclk(4); check_disp("rst_d1", 4'hD, 7'h40, 1'b1);
    waitclk(4); check_disp("rst_d2", 4'hB, 7'h40, 1'b0);
    waitclk(4); check_disp("rst_d3", 4'h7, 7'h40, 1'b1);

    // Out-of-range seconds show dashes; 59 minutes
    waitclk(4); check_disp("dash_d0", 4'hE, 7'h3F, 1'b1);
    waitclk(4); check_disp("dash_d1", 4'hD, 7'h3F, 1'b1);
    waitclk(4); check_disp("m59_d2", 4'hB, 7'h10, 1'b0);
    waitclk(4); check_disp("m59_d3", 4'h7, 7'h12, 1'b1);

    // Blank for 10 clocks; scan keeps running underneath
    blank = 1'b1;
    waitclk(1); check_disp("blank_1", 4'hF, 7'h7F, 1'b1);
    waitclk(5); check_disp("blank_6", 4'hF, 7'h7F, 1'b1);
    waitclk(4); check_disp("blank_10", 4'hF, 7'h7F, 1'b1);
    blank = 1'b0;
    waitclk(1); check_disp("unblank_d1", 4'hD, 7'h3F, 1'b1);
    waitclk(1); check_disp("unblank_d2", 4'hB, 7'h10, 1'b0);
    waitclk(3); check_disp("unblank_d2_hold", 4'hB, 7'h10, 1'b0);
    waitclk(1); check_disp("unblank_d3", 4'h7, 7'h12, 1'b1);

`ifdef STOPWATCH_BLINK_EN
    begin
      int n_dark;
      blink  = 1'b1;
      n_dark = 0;
      for (int i = 0; i < 40; i++) begin
        waitclk(1);
        if (an == 4'hF) n_dark++;
      end
      check_val("blink_dark_cycles", 32'(n_dark), 32'd20);
      blink  = 1'b0;
      n_dark = 0;
      for (int i = 0; i < 20; i++) begin
        waitclk(1);
        if (an == 4'hF) n_dark++;
      end
      check_val("noblink_dark_cycles", 32'(n_dark), 32'd0);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
